pulse_transmitter_stream: RTL and testbench
===========================================

Name: pulse_transmitter_stream

Overview:
Parametrised, streaming successor to the TinyQV pulse transmitter core. Fixed symbol memory is replaced by a FIFO of explicit pulses {level, duration} fed over a valid/ready handshake. Pulses are emitted back-to-back with no gap, with per-pulse prescaling, optional carrier modulation, idle level and inversion. Underflow and end-of-stream are reported as event pulses. Sits under a TinyQV peripheral wrapper, which maps the events into its interrupt register.

Parameters:
DUR_W, 16, width of pulse duration field.
PRESC_W, 4, width of prescaler exponent; prescaler counter is (2**PRESC_W)-1 bits.
FIFO_DEPTH, 8, pulse FIFO entries; power of 2, >=2.
CARRIER_W, 16, width of carrier half-period.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
en  in  1  run enable; low aborts transmission
flush  in  1  clear FIFO contents
cfg_prescaler  in  PRESC_W  exponent p; one tick = 2**p cycles
cfg_idle_level  in  1  level driven when not transmitting
cfg_invert  in  1  invert pulse_out
cfg_carrier_en  in  1  AND active level with carrier
cfg_carrier_half  in  CARRIER_W  carrier half-period minus 1
s_valid  in  1  pulse entry valid
s_level  in  1  pulse level
s_duration  in  DUR_W  pulse length in ticks minus 1
s_last  in  1  final pulse of stream
s_ready  out  1  FIFO accepts entry
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held
busy  out  1  state != IDLE
valid_out  out  1  state == ACTIVE
carrier_out  out  1  raw carrier
pulse_out  out  1  final line output
evt_pulse_done  out  1  one-cycle strobe, end of each pulse
evt_last_done  out  1  one-cycle strobe, end of s_last pulse
evt_underflow  out  1  one-cycle strobe, FIFO empty at pulse end

Behaviour:
- Reset (after first clk edge with rst_n low):
  - FIFO empty, fifo_count=0, state IDLE.
  - busy=valid_out=carrier_out=0, all evt_*=0.
  - s_ready=1, pulse_out=cfg_idle_level^cfg_invert.
- FIFO:
  - s_ready = !full && !flush. Push on s_valid&&s_ready.
  - Full: s_ready=0 even if a pop occurs the same cycle.
  - A pushed entry is poppable from the next cycle.
  - Simultaneous push+pop: fifo_count unchanged.
  - flush: next cycle count=0; pointers reset; state unaffected. The current pulse finishes, then underflow (or last) rules apply.
- States IDLE, ACTIVE, STALL. Load = pop head; latch level, duration and cfg_prescaler.
  - IDLE, en=1, count>0: load; ACTIVE next cycle.
  - ACTIVE: pulse lasts exactly (duration+1)*2**p cycles. The final cycle asserts evt_pulse_done, then:
    - entry had last: evt_last_done; next IDLE.
    - else count>0: load; stay ACTIVE with no gap cycle.
    - else: evt_underflow; next STALL.
  - STALL, count>0: load; ACTIVE next cycle. STALL, en=0: IDLE.
  - en=0 in any state: IDLE next cycle, no events, FIFO retained. Current pulse is discarded.
  - en=0 overrides pulse-end transitions in the same cycle.
- Config changes mid-pulse: prescaler takes effect at the next load. Idle, invert and carrier settings apply immediately.
- Carrier:
  - While not ACTIVE: carrier_out=0, counter=cfg_carrier_half.
  - In ACTIVE: counter decrements; at 0 it reloads and carrier_out toggles. carrier_out toggles every cfg_carrier_half+1 cycles; the first toggle comes after cfg_carrier_half+1 ACTIVE cycles.
  - Carrier phase is continuous across back-to-back pulses.
- Output:
  - pulse_out = (valid_out ? (level & (carrier_out | !cfg_carrier_en)) : cfg_idle_level) ^ cfg_invert.
  - pulse_out is combinational from registers and cfg only; no path from s_* inputs.
- Counters saturate nowhere; max pulse is 2**DUR_W * 2**(2**PRESC_W-1) cycles.
- Reset mid-operation: as reset above; FIFO contents lost.

Test Plan:
- p=0, push {1,dur=3,last=0},{0,dur=1,last=1} while en=0; raise en at cycle T -> valid_out from T+1; pulse_out=1 for 4 cycles then 0 for 2; evt_pulse_done at T+4 and T+6; evt_last_done at T+6; IDLE at T+7.
- p=2, single {1,dur=0,last=1} -> pulse_out high exactly 4 cycles; cfg_invert=1 gives inverted waveform, idle=!cfg_idle_level.
- Push 9 entries into depth-8 FIFO with en=0 -> s_ready=0 after 8th push, fifo_count=8; 9th held until first pop; flush -> count=0 next cycle; flush+s_valid same cycle -> no push.
- Stream {1,dur=2,last=0} only -> evt_underflow at end, STALL with pulse_out=idle; push {0,dur=0,last=1} -> ACTIVE the cycle after it becomes poppable; last completes normally.
- cfg_carrier_en=1, half=1, pulse {1,dur=7}, p=0 -> pulse_out pattern 0,0,1,1,0,0,1,1 across 8 cycles; back-to-back second high pulse continues phase.
- Drop en mid-pulse at cycle 3 of 10 -> IDLE next cycle, no evt_*, remaining FIFO entries intact; re-raise en -> next entry starts fresh.

Source files
------------

// File: rtl/pulse_transmitter_stream.sv
// Streaming pulse transmitter: a FIFO of {level, duration, last} entries played
// back-to-back on pulse_out, with per-pulse prescaling and optional carrier.
module pulse_transmitter_stream #(
  parameter int unsigned DUR_W      = 16,
  parameter int unsigned PRESC_W    = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CARRIER_W  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          flush,
  input  logic [PRESC_W-1:0]            cfg_prescaler,
  input  logic                          cfg_idle_level,
  input  logic                          cfg_invert,
  input  logic                          cfg_carrier_en,
  input  logic [CARRIER_W-1:0]          cfg_carrier_half,
  input  logic                          s_valid,
  input  logic                          s_level,
  input  logic [DUR_W-1:0]              s_duration,
  input  logic                          s_last,
  output logic                          s_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          valid_out,
  output logic                          carrier_out,
  output logic                          pulse_out,
  output logic                          evt_pulse_done,
  output logic                          evt_last_done,
  output logic                          evt_underflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = (1 << PRESC_W) - 1;
  localparam int unsigned EW = DUR_W + 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STALL  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [EW-1:0] head;
  logic          full, avail, push, load;

  logic                 level_r, last_r;
  logic [DUR_W-1:0]     dur_cnt;
  logic [PRESC_W-1:0]   presc_r;
  logic [PW-1:0]        presc_cnt;
  logic [CARRIER_W-1:0] car_cnt;
  logic                 pulse_end;

  // Cycles per tick minus one; wraps correctly when p fills the counter width.
  function automatic logic [PW-1:0] tick_reload(input logic [PRESC_W-1:0] p);
    return (PW'(1) << p) - PW'(1);
  endfunction

  assign full    = (fifo_count == CW'(FIFO_DEPTH));
  assign avail   = (fifo_count != '0);
  assign s_ready = !full && !flush;
  assign push    = s_valid && s_ready;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s_last, s_level, s_duration};
  end

  // FIFO pointers and occupancy; a flush wins over any push/pop that cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (load) rd_ptr <= rd_ptr + AW'(1);
      case ({push, load})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign pulse_end = (state == ACTIVE) && (presc_cnt == '0) && (dur_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state, head pop and end-of-pulse events; en low suppresses all of them.
  always_comb begin
    state_next     = state;
    load           = 1'b0;
    evt_pulse_done = 1'b0;
    evt_last_done  = 1'b0;
    evt_underflow  = 1'b0;
    if (!en) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, STALL: begin
          if (avail) begin
            load       = 1'b1;
            state_next = ACTIVE;
          end
        end
        ACTIVE: begin
          if (pulse_end) begin
            evt_pulse_done = 1'b1;
            if (last_r) begin
              evt_last_done = 1'b1;
              state_next    = IDLE;
            end else if (avail) begin
              load = 1'b1;
            end else begin
              evt_underflow = 1'b1;
              state_next    = STALL;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Current pulse: latched entry plus tick prescaler and duration countdown.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_r   <= 1'b0;
      last_r    <= 1'b0;
      dur_cnt   <= '0;
      presc_r   <= '0;
      presc_cnt <= '0;
    end else if (load) begin
      dur_cnt   <= head[DUR_W-1:0];
      level_r   <= head[DUR_W];
      last_r    <= head[DUR_W+1];
      presc_r   <= cfg_prescaler;
      presc_cnt <= tick_reload(cfg_prescaler);
    end else if (state == ACTIVE) begin
      if (presc_cnt != '0) begin
        presc_cnt <= presc_cnt - PW'(1);
      end else if (dur_cnt != '0) begin
        dur_cnt   <= dur_cnt - DUR_W'(1);
        presc_cnt <= tick_reload(presc_r);
      end
    end
  end

  // Carrier is held reset outside ACTIVE and free-runs across back-to-back pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      car_cnt     <= '0;
      carrier_out <= 1'b0;
    end else if (state != ACTIVE || state_next != ACTIVE) begin
      car_cnt     <= cfg_carrier_half;
      carrier_out <= 1'b0;
    end else if (car_cnt == '0) begin
      car_cnt     <= cfg_carrier_half;
      carrier_out <= !carrier_out;
    end else begin
      car_cnt <= car_cnt - CARRIER_W'(1);
    end
  end

  assign busy      = (state != IDLE);
  assign valid_out = (state == ACTIVE);
  assign pulse_out = (valid_out ? (level_r & (carrier_out | !cfg_carrier_en))
                                : cfg_idle_level) ^ cfg_invert;

endmodule

// File: tb/tb_pulse_transmitter_stream.sv
// Scoreboard bench for pulse_transmitter_stream: stimulus queues the expected
// pulse shape, a monitor compares each completed pulse against it.
module tb_pulse_transmitter_stream;

  logic        clk, rst_n, en, flush;
  logic [3:0]  cfg_prescaler;
  logic        cfg_idle_level, cfg_invert, cfg_carrier_en;
  logic [15:0] cfg_carrier_half;
  logic        s_valid, s_level, s_last;
  logic [15:0] s_duration;
  logic        s_ready;
  logic [3:0]  fifo_count;
  logic        busy, valid_out, carrier_out, pulse_out;
  logic        evt_pulse_done, evt_last_done, evt_underflow;

  pulse_transmitter_stream dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
    .cfg_prescaler(cfg_prescaler), .cfg_idle_level(cfg_idle_level),
    .cfg_invert(cfg_invert), .cfg_carrier_en(cfg_carrier_en),
    .cfg_carrier_half(cfg_carrier_half),
    .s_valid(s_valid), .s_level(s_level), .s_duration(s_duration), .s_last(s_last),
    .s_ready(s_ready), .fifo_count(fifo_count), .busy(busy), .valid_out(valid_out),
    .carrier_out(carrier_out), .pulse_out(pulse_out),
    .evt_pulse_done(evt_pulse_done), .evt_last_done(evt_last_done),
    .evt_underflow(evt_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          len;
    logic [63:0] pat;
    logic        last;
    logic        uf;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_pulse = 0;

  function automatic logic [63:0] ones(input int n);
    return (64'(1) << n) - 64'(1);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_pulse(input int len, input logic [63:0] pat,
                              input logic last, input logic uf);
    exp_t e;
    e.len = len; e.pat = pat; e.last = last; e.uf = uf;
    sb.push_back(e);
  endtask

  // Records pulse_out while valid_out is high; compares on each evt_pulse_done.
  task automatic monitor();
    int          cur_len;
    logic [63:0] cur_pat;
    exp_t        e;
    cur_len = 0;
    cur_pat = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cur_len = 0; cur_pat = '0;
        continue;
      end
      if (valid_out) begin
        cur_pat = {cur_pat[62:0], pulse_out};
        cur_len++;
      end else begin
        cur_len = 0; cur_pat = '0;
      end
      if (evt_pulse_done) begin
        n_vec++;
        n_pulse++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL pulse%0d: unexpected evt_pulse_done len=%0d pat=%0h",
                   n_pulse, cur_len, cur_pat);
        end else begin
          e = sb.pop_front();
          if (cur_len != e.len || cur_pat != e.pat ||
              evt_last_done != e.last || evt_underflow != e.uf) begin
            n_err++;
            $display("FAIL pulse%0d: got len=%0d pat=%0h last=%0b uf=%0b, expected len=%0d pat=%0h last=%0b uf=%0b",
                     n_pulse, cur_len, cur_pat, evt_last_done, evt_underflow,
                     e.len, e.pat, e.last, e.uf);
          end
        end
        cur_len = 0; cur_pat = '0;
      end else if (evt_last_done || evt_underflow) begin
        n_vec++;
        n_err++;
        $display("FAIL stray_event: last=%0b uf=%0b without evt_pulse_done",
                 evt_last_done, evt_underflow);
      end
    end
  endtask

  task automatic send(input logic lv, input int dur, input logic last);
    bit ok = 0;
    @(posedge clk); #1;
    s_valid = 1'b1; s_level = lv; s_duration = 16'(dur); s_last = last;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL send: s_ready stuck low, got 0 expected 1");
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!busy && fifo_count == 0 && sb.size() == 0) begin ok = 1; break; end
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL wait_done: busy=%0b count=%0d pending=%0d, expected all 0",
               busy, fifo_count, sb.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    bit ok;
    rst_n = 0; en = 0; flush = 0;
    cfg_prescaler = 0; cfg_idle_level = 0; cfg_invert = 0;
    cfg_carrier_en = 0; cfg_carrier_half = 0;
    s_valid = 0; s_level = 0; s_duration = 0; s_last = 0;
    fork monitor(); join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_count", int'(fifo_count), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(valid_out), 0);
    check("rst_carrier", int'(carrier_out), 0);
    check("rst_evts", int'({evt_pulse_done, evt_last_done, evt_underflow}), 0);
    check("rst_ready", int'(s_ready), 1);
    check("rst_pulse_out", int'(pulse_out), 0);
    cfg_idle_level = 1; #1;
    check("rst_idle1", int'(pulse_out), 1);
    cfg_invert = 1; #1;
    check("rst_idle1_inv", int'(pulse_out), 0);
    cfg_idle_level = 0; cfg_invert = 0;
    @(posedge clk); #1 rst_n = 1;

    // Two-pulse stream, p=0
    expect_pulse(4, ones(4), 1'b0, 1'b0);
    expect_pulse(2, 64'd0, 1'b1, 1'b0);
    send(1, 3, 0);
    send(0, 1, 1);
    @(negedge clk); check("t1_count", int'(fifo_count), 2);
    @(posedge clk); #1 en = 1;
    @(negedge clk); check("t1_valid_T", int'(valid_out), 0);
    @(negedge clk); check("t1_valid_T1", int'(valid_out), 1);
    repeat (2) @(negedge clk);
    @(negedge clk); check("t1_done_T4", int'(evt_pulse_done), 1);
    @(negedge clk);
    @(negedge clk); check("t1_last_T6", int'(evt_last_done), 1);
    @(negedge clk); check("t1_idle_T7", int'(busy), 0);
    wait_done();
    @(posedge clk); #1 en = 0;

    // Prescaler p=2, then inverted output
    @(posedge clk); #1 cfg_prescaler = 2; en = 1;
    expect_pulse(4, ones(4), 1'b1, 1'b0);
    send(1, 0, 1);
    wait_done();
    @(posedge clk); #1 cfg_invert = 1;
    @(negedge clk); check("t2_idle_inv", int'(pulse_out), 1);
    expect_pulse(4, 64'd0, 1'b1, 1'b0);
    send(1, 0, 1);
    wait_done();
    @(posedge clk); #1 cfg_invert = 0; cfg_prescaler = 0; en = 0;

    // Fill FIFO, hold a 9th entry until the first pop
    for (int i = 0; i < 8; i++) begin
      expect_pulse(1, 64'(i % 2), 1'b0, 1'b0);
      send(1'(i % 2), 0, 0);
    end
    expect_pulse(1, 64'd1, 1'b1, 1'b0);
    @(negedge clk);
    check("t3_full_count", int'(fifo_count), 8);
    check("t3_full_ready", int'(s_ready), 0);
    @(posedge clk); #1 s_valid = 1; s_level = 1; s_duration = 0; s_last = 1;
    @(negedge clk); check("t3_held_ready", int'(s_ready), 0);
    @(posedge clk); #1 en = 1;
    @(negedge clk); check("t3_count_prepop", int'(fifo_count), 8);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL t3_ready_after_pop: got 0 expected 1");
    end
    @(posedge clk); #1 s_valid = 0;
    wait_done();
    @(posedge clk); #1 en = 0;

    // Flush, with a concurrent s_valid that must be dropped
    send(1, 5, 0); send(0, 5, 0); send(1, 5, 1);
    @(negedge clk); check("t3_flush_pre", int'(fifo_count), 3);
    @(posedge clk); #1 flush = 1; s_valid = 1; s_level = 1; s_duration = 0; s_last = 1;
    @(negedge clk); check("t3_flush_ready", int'(s_ready), 0);
    @(posedge clk); #1 flush = 0; s_valid = 0;
    @(negedge clk); check("t3_flush_count", int'(fifo_count), 0);
    @(negedge clk); check("t3_flush_busy", int'(busy), 0);

    // Underflow into STALL, then resume with a last pulse
    @(posedge clk); #1 cfg_idle_level = 1; en = 1;
    expect_pulse(3, ones(3), 1'b0, 1'b1);
    send(1, 2, 0);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy && !valid_out) begin ok = 1; break; end
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL t4_stall: STALL never reached, busy=%0b valid=%0b", busy, valid_out);
    end
    check("t4_stall_idle_level", int'(pulse_out), 1);
    check("t4_stall_carrier", int'(carrier_out), 0);
    expect_pulse(1, 64'd0, 1'b1, 1'b0);
    send(0, 0, 1);
    @(negedge clk); check("t4_resume_pre", int'(valid_out), 0);
    @(negedge clk); check("t4_resume_active", int'(valid_out), 1);
    wait_done();
    @(posedge clk); #1 cfg_idle_level = 0; en = 0;

    // Carrier, half=1 and half=2, phase continuous across pulses
    @(posedge clk); #1 cfg_carrier_en = 1; cfg_carrier_half = 1;
    expect_pulse(8, 64'b00110011, 1'b0, 1'b0);
    expect_pulse(8, 64'b00110011, 1'b1, 1'b0);
    send(1, 7, 0); send(1, 7, 1);
    @(posedge clk); #1 en = 1;
    wait_done();
    @(posedge clk); #1 en = 0; cfg_carrier_half = 2;
    expect_pulse(5, 64'b00011, 1'b0, 1'b0);
    expect_pulse(5, 64'b10001, 1'b1, 1'b0);
    send(1, 4, 0); send(1, 4, 1);
    @(posedge clk); #1 en = 1;
    wait_done();
    @(negedge clk); check("t5_carrier_idle", int'(carrier_out), 0);
    @(posedge clk); #1 en = 0; cfg_carrier_en = 0; cfg_carrier_half = 0;

    // Abort mid-pulse with en, then restart on the next entry
    send(1, 9, 0); send(0, 1, 0); send(1, 0, 1);
    expect_pulse(2, 64'd0, 1'b0, 1'b0);
    expect_pulse(1, 64'd1, 1'b1, 1'b0);
    @(posedge clk); #1 en = 1;
    @(negedge clk);
    @(negedge clk); check("t6_active", int'(valid_out), 1);
    @(negedge clk);
    @(posedge clk); #1 en = 0;
    @(negedge clk); check("t6_abort_busy", int'(busy), 1);
    @(negedge clk);
    check("t6_idle", int'(busy), 0);
    check("t6_fifo_kept", int'(fifo_count), 2);
    @(posedge clk); #1 en = 1;
    wait_done();
    @(posedge clk); #1 en = 0;

    // Reset mid-operation
    send(1, 20, 1); send(0, 3, 1);
    @(posedge clk); #1 en = 1;
    repeat (5) @(negedge clk);
    @(posedge clk); #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1; en = 0;
    @(negedge clk);
    check("t7_count", int'(fifo_count), 0);
    check("t7_busy", int'(busy), 0);
    check("t7_pulse_out", int'(pulse_out), 0);
    check("t7_ready", int'(s_ready), 1);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
